intersection_ctrl: RTL and testbench

Two-road intersection sequencer built on the three-lamp cyclic scheme: drives one main-road and one side-road lamp with the team's one-hot R/G/Y encoding. It also serves vehicle-sensor and pedestrian-button requests, with programmable dwell times and all-red clearance. It sits between the road-side sensor inputs and the lamp drivers. It replaces free-running cycling with demand-driven phases.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/dwell_timer.sv | 16 +
 rtl/intersection_ctrl.sv | 69 ++++++
 tb/tb_intersection_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lamp codes, intersection state codes and timer sizing helper
package traffic_pkg;
    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_A    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_B    = 3'd5
    } state_t;
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        m = b > m ? b : m;
        m = c > m ? c : m;
        m = d > m ? d : m;
        return m > 1 ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: saturating down-counter; clock, reset (to INIT), load/load_val, done when zero
module dwell_timer #(
    parameter int W = 3,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clock)
        cnt <= reset ? INIT : load ? load_val : done ? cnt : cnt - W'(1);
    assign done = cnt == '0;
endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: demand-driven main/side lamp sequencer; clock, reset, side_req, ped_req in; main_light, side_light, walk, phase out
module intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN_T  = 8,
    parameter int SIDE_GREEN_T = 6,
    parameter int YELLOW_T     = 3,
    parameter int ALLRED_T     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [0:2] main_light,
    output logic [0:2] side_light,
    output logic       walk,
    output logic [0:2] phase
);
    localparam int TW = timer_width(GREEN_MIN_T, SIDE_GREEN_T, YELLOW_T, ALLRED_T);
    localparam logic [TW-1:0] GM = TW'(GREEN_MIN_T - 1);
    localparam logic [TW-1:0] SG = TW'(SIDE_GREEN_T - 1);
    localparam logic [TW-1:0] YW = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR = TW'(ALLRED_T - 1);
    state_t        state, nxt;
    logic [TW-1:0] dwell;
    logic          done, pending, ped_pending, walk_r, enter_sg, leave_sg;
    dwell_timer #(.W(TW), .INIT(GM)) timer (
        .clock   (clock),
        .reset   (reset),
        .load    (nxt != state),
        .load_val(dwell),
        .done    (done)
    );
    always_comb begin
        nxt = MAIN_GREEN;
        case (state)
            MAIN_GREEN:  nxt = done && pending ? MAIN_YELLOW : MAIN_GREEN;
            MAIN_YELLOW: nxt = done ? ALLRED_A : MAIN_YELLOW;
            ALLRED_A:    nxt = done ? SIDE_GREEN : ALLRED_A;
            SIDE_GREEN:  nxt = done ? SIDE_YELLOW : SIDE_GREEN;
            SIDE_YELLOW: nxt = done ? ALLRED_B : SIDE_YELLOW;
            ALLRED_B:    nxt = done ? MAIN_GREEN : ALLRED_B;
            default:     nxt = MAIN_GREEN;
        endcase
        dwell = nxt == MAIN_GREEN ? GM :
                nxt == SIDE_GREEN ? SG :
                (nxt == MAIN_YELLOW || nxt == SIDE_YELLOW) ? YW : AR;
    end
    assign enter_sg = state == ALLRED_A && done;
    assign leave_sg = state == SIDE_GREEN && done;
    // entering side green clears the request latches even if a request arrives on that edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= MAIN_GREEN;
            pending     <= 1'b0;
            ped_pending <= 1'b0;
            walk_r      <= 1'b0;
        end else begin
            state       <= nxt;
            pending     <= !enter_sg && (pending || side_req || ped_req);
            ped_pending <= !enter_sg && (ped_pending || ped_req);
            walk_r      <= enter_sg ? ped_pending : leave_sg ? 1'b0 : walk_r;
        end
    end
    assign main_light = state == MAIN_GREEN ? GREEN : state == MAIN_YELLOW ? YELLOW : RED;
    assign side_light = state == SIDE_GREEN ? GREEN : state == SIDE_YELLOW ? YELLOW : RED;
    assign walk       = walk_r;
    assign phase      = state;
endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed schedule scoreboard plus randomized lamp-safety checks
module tb_intersection_ctrl;
    localparam int YT = 3, ART = 1, SGT = 6;
    logic       clock = 1'b0;
    logic       reset = 1'b0, side_req = 1'b0, ped_req = 1'b0;
    logic [0:2] main_light, side_light, phase;
    logic       walk;
    logic       rnd = 1'b0;
    logic [0:2] prev_m = 3'b100, prev_s = 3'b100;
    int         checks = 0, errors = 0;
    typedef struct packed {
        logic [0:2] m;
        logic [0:2] s;
        logic       w;
        logic [2:0] p;
    } obs_t;
    obs_t q[$];

    intersection_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .side_req  (side_req),
        .ped_req   (ped_req),
        .main_light(main_light),
        .side_light(side_light),
        .walk      (walk),
        .phase     (phase)
    );

    always #5 clock = ~clock;

    function automatic obs_t expect_of(input int ph, input logic w);
        obs_t e;
        e.p = 3'(ph);
        e.w = w;
        e.m = ph == 0 ? 3'b010 : ph == 1 ? 3'b001 : 3'b100;
        e.s = ph == 3 ? 3'b010 : ph == 4 ? 3'b001 : 3'b100;
        return e;
    endfunction

    function automatic int sched(input int n, input int y);
        int d;
        if (y < 0 || n < y) return 0;
        d = n - y;
        if (d < YT) return 1;
        d -= YT;
        if (d < ART) return 2;
        d -= ART;
        if (d < SGT) return 3;
        d -= SGT;
        if (d < YT) return 4;
        d -= YT;
        if (d < ART) return 5;
        return 0;
    endfunction

    task automatic compare(input string tag);
        obs_t got, exp;
        got = {main_light, side_light, walk, phase};
        exp = q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got m=%b s=%b w=%b p=%0d expected m=%b s=%b w=%b p=%0d",
                   tag, got.m, got.s, got.w, got.p, exp.m, exp.s, exp.w, exp.p);
        end
    endtask

    task automatic step(input logic s, input logic p, input obs_t e, input string tag);
        side_req = s;
        ped_req  = p;
        q.push_back(e);
        @(posedge clock);
        #1;
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        side_req = 1'b0;
        ped_req  = 1'b0;
        q.push_back(expect_of(0, 1'b0));
        @(posedge clock);
        #1;
        compare(tag);
        checks++;
        assert (dut.pending === 1'b0) else begin
            errors++;
            $error("FAIL %s_pending got %b expected 0", tag, dut.pending);
        end
        reset = 1'b0;
    endtask

    // edges numbered from the reset edge; y1/y2 are the edges after which MAIN_YELLOW is expected
    task automatic run_seq(input int edges, input int req, input bit is_ped, input int y1,
                           input int req2, input int y2, input string tag);
        int ph;
        for (int n = 1; n <= edges; n++) begin
            ph = (y2 >= 0 && n >= y2) ? sched(n, y2) : sched(n, y1);
            step((n == req && !is_ped) || n == req2, n == req && is_ped,
                 expect_of(ph, is_ped && sched(n, y1) == 3), tag);
        end
    endtask

    always @(negedge clock) begin
        if (rnd) begin
            checks++;
            assert (main_light == 3'b100 || side_light == 3'b100) else begin
                errors++;
                $error("FAIL both_lit got m=%b s=%b expected one lamp 100", main_light, side_light);
            end
            checks++;
            assert (!(prev_m == 3'b010 && main_light == 3'b100) &&
                    !(prev_s == 3'b010 && side_light == 3'b100)) else begin
                errors++;
                $error("FAIL green_to_red got m=%b->%b s=%b->%b expected yellow between",
                       prev_m, main_light, prev_s, side_light);
            end
        end
        prev_m <= main_light;
        prev_s <= side_light;
    end

    initial begin
        @(posedge clock);
        #1;
        do_reset("reset_idle");
        run_seq(60, -1, 1'b0, -1, -1, -1, "idle");
        do_reset("reset_side");
        run_seq(30, 2, 1'b0, 8, -1, -1, "side_pulse");
        do_reset("reset_ped");
        run_seq(30, 3, 1'b1, 8, -1, -1, "ped_pulse");
        do_reset("reset_twice");
        run_seq(60, 20, 1'b0, 21, 27, 43, "side_twice");
        do_reset("reset_abort");
        run_seq(13, 3, 1'b1, 8, -1, -1, "ped_abort");
        do_reset("mid_reset");
        run_seq(30, -1, 1'b0, -1, -1, -1, "not_served");
        rnd = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            side_req = 1'($urandom_range(0, 1));
            ped_req  = $urandom_range(0, 7) == 0;
            @(posedge clock);
            #1;
        end
        rnd = 1'b0;
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
